// File: rtl/counter_sched_pkg.sv
//==============================================================================
// Module   : counter_sched_pkg
// Brief    : Shared types and helpers for the round-robin pulse-counter
//            scheduler.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package counter_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } sched_state_t;

  // Width of a requester index; never below one bit.
  function automatic int owner_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_scheduler_rr_arbiter.sv
//==============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first asserted request at or
//            after the pointer, wrapping modulo NREQ.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int OW   = owner_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic [OW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  int w_slot;

  // Scan NREQ slots starting at ptr and keep the first one that requests.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    w_slot    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_slot = int'(ptr) + k;
      if (w_slot >= NREQ) begin
        w_slot = w_slot - NREQ;
      end
      if (!gnt_valid && req[OW'(w_slot)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = OW'(w_slot);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_scheduler.sv
//==============================================================================
// Module   : counter_scheduler
// Brief    : Shares one pulse-timing counter among NREQ requesters. Grants
//            round-robin, latches the owner's threshold and drives pulse_out
//            high for exactly that many cycles, then reports done.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int CW   = 32,
  localparam int OW   = owner_width(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] threshold,
  output logic [NREQ-1:0]  ack,
  output logic [NREQ-1:0]  done,
  output logic             pulse_out,
  output logic [OW-1:0]    owner,
  output logic             busy
);

  sched_state_t   r_state;
  logic [CW-1:0]  r_thr;
  logic [CW-1:0]  r_cnt;
  logic [OW-1:0]  r_ptr;

  logic [OW-1:0]  w_gnt_idx;
  logic           w_gnt_valid;
  logic [OW-1:0]  w_next_ptr;
  logic [CW-1:0]  w_thr_slot [NREQ];

  // Unpack the flat threshold bus into one slot per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_thr_slot
    assign w_thr_slot[i] = threshold[i*CW +: CW];
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req       (req),
    .ptr       (r_ptr),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  // After a finished or aborted job the search starts just past the owner.
  assign w_next_ptr = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);

  // Decoded from the state register only, so no input-to-output path.
  assign busy = (r_state != S_IDLE);

  // Scheduler FSM, shared counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_thr     <= '0;
      r_cnt     <= '0;
      r_ptr     <= '0;
      owner     <= '0;
      ack       <= '0;
      done      <= '0;
      pulse_out <= 1'b0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_thr   <= w_thr_slot[w_gnt_idx];
            r_cnt   <= '0;
            owner   <= w_gnt_idx;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          ack[owner] <= 1'b1;
          if (r_thr == '0) begin
            r_state <= S_DONE;
          end else begin
            pulse_out <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          // A withdrawn request wins over normal completion: no done.
          if (!req[owner]) begin
            pulse_out <= 1'b0;
            r_ptr     <= w_next_ptr;
            r_state   <= S_IDLE;
          end else if (r_cnt == r_thr - CW'(1)) begin
            pulse_out <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          done[owner] <= 1'b1;
          r_ptr       <= w_next_ptr;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_scheduler.sv
//==============================================================================
// Module   : tb_counter_scheduler
// Brief    : Self-checking bench for counter_scheduler (NREQ=4, CW=8).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_counter_scheduler;

  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int OW   = 2;
  localparam int BUDGET = 600;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*CW-1:0] threshold = '0;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic              pulse_out;
  logic [OW-1:0]     owner;
  logic              busy;

  counter_scheduler #(
    .NREQ (NREQ),
    .CW   (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .threshold (threshold),
    .ack       (ack),
    .done      (done),
    .pulse_out (pulse_out),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int t;
  } exp_t;

  typedef struct {
    logic [NREQ-1:0] mask;
    int              t;
    int              exp_idx;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mon_ack_idx = -1;
  int   mon_ack_cyc = 0;
  int   mon_pulses = 0;

  task automatic check(input string name, input int act, input int req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req_v, $time);
    end
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected jobs are popped when the DUT reports done.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (ack != '0) begin
        check("ack_onehot", $countones(ack), 1);
        mon_ack_idx = idx_of(ack);
        mon_ack_cyc = cyc;
        mon_pulses  = 0;
      end
      if (pulse_out) mon_pulses++;
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          e = exp_q.pop_front();
          check("done_vec", int'(done), 1 << e.idx);
          check("done_owner", int'(owner), e.idx);
          check("ack_idx", mon_ack_idx, e.idx);
          check("pulse_len", mon_pulses, e.t);
          check("ack_to_done", cyc - mon_ack_cyc, e.t + 1);
          check("pulse_at_done", int'(pulse_out), 0);
        end
      end
    end
  end

  task automatic set_thr(input int s, input int v);
    threshold[s*CW +: CW] = CW'(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack == '0 && lat < BUDGET);
    if (ack == '0) check("ack_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < BUDGET);
    if (done == '0) check("done_timeout", 0, 1);
  endtask

  vec_t vecs[7];

  initial begin
    int lat;
    int last_done;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_done", int'(done), 0);
    check("rst_pulse", int'(pulse_out), 0);
    check("rst_owner", int'(owner), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Pointer starts at 0; each vector's winner moves it to winner+1.
    vecs[0] = '{mask: 4'b0010, t: 5, exp_idx: 1};
    vecs[1] = '{mask: 4'b0100, t: 0, exp_idx: 2};
    vecs[2] = '{mask: 4'b1001, t: 3, exp_idx: 3};
    vecs[3] = '{mask: 4'b1001, t: 2, exp_idx: 0};
    vecs[4] = '{mask: 4'b0001, t: 1, exp_idx: 0};
    vecs[5] = '{mask: 4'b1100, t: 4, exp_idx: 2};
    vecs[6] = '{mask: 4'b0110, t: 2, exp_idx: 1};

    foreach (vecs[i]) begin
      wait_idle();
      for (int s = 0; s < NREQ; s++)
        set_thr(s, (s == vecs[i].exp_idx) ? vecs[i].t : 8'hA0 + s);
      req = vecs[i].mask;
      exp_q.push_back('{idx: vecs[i].exp_idx, t: vecs[i].t});
      wait_ack(lat);
      check("ack_latency", lat, 2);
      check("grant_owner", int'(owner), vecs[i].exp_idx);
      // Changes after latching must not affect the running pulse.
      threshold = NREQ*CW'($urandom);
      wait_done();
      req = '0;
    end

    // Round-robin: all requesting, T=1, order 0,1,2,3,0, dones 4 apart.
    do_reset();
    for (int s = 0; s < NREQ; s++) set_thr(s, 1);
    for (int k = 0; k < 5; k++) exp_q.push_back('{idx: k % NREQ, t: 1});
    req = 4'b1111;
    last_done = 0;
    for (int k = 0; k < 5; k++) begin
      wait_done();
      if (k > 0) check("rr_spacing", cyc - last_done, 4);
      last_done = cyc;
    end
    req = '0;

    // Abort: req[0] dropped 3 cycles into RUN, then requester 1 is served.
    do_reset();
    set_thr(0, 10);
    set_thr(1, 2);
    exp_q.push_back('{idx: 1, t: 2});
    req = 4'b0011;
    wait_ack(lat);
    check("abort_owner", int'(owner), 0);
    repeat (3) @(negedge clk);
    check("abort_pulse_before", int'(pulse_out), 1);
    req[0] = 1'b0;
    @(negedge clk);
    check("abort_pulse_after", int'(pulse_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_no_done", int'(done), 0);
    check("abort_pulse_len", mon_pulses, 4);
    wait_done();
    req = '0;

    // Reset mid-RUN: outputs clear without a clock edge.
    do_reset();
    set_thr(3, 100);
    req = 4'b1000;
    wait_ack(lat);
    repeat (50) @(negedge clk);
    check("midrun_pulse", int'(pulse_out), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ack", int'(ack), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_pulse", int'(pulse_out), 0);
    check("async_rst_owner", int'(owner), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    set_thr(3, 3);
    exp_q.push_back('{idx: 3, t: 3});
    reset = 1'b0;
    wait_ack(lat);
    check("post_rst_latency", lat, 2);
    check("post_rst_owner", int'(owner), 3);
    wait_done();
    req = '0;

    // Maximum threshold for CW=8.
    wait_idle();
    set_thr(2, 8'hFF);
    exp_q.push_back('{idx: 2, t: 255});
    req = 4'b0100;
    wait_ack(lat);
    wait_done();
    req = '0;

    repeat (3) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
